// File: rtl/lazy_summary_scheduler_pkg.sv
// rtl/lazy_summary_scheduler_pkg.sv - shared widths, constants and FSM state type for the summary scheduler
package lazy_summary_scheduler_pkg;

    localparam int JOB_LEN         = 64;
    localparam int JOB_LEN_LOG2    = 6;
    localparam int SEQ_LL_BITS     = 8;
    localparam int SEQ_ML_BITS     = 8;
    localparam int SEQ_OFFSET_BITS = 16;
    // move_forward may equal JOB_LEN, so it needs one bit more than a head pointer
    localparam int MOVE_BITS       = JOB_LEN_LOG2 + 1;

    // JOB_LEN expressed in the width of the skip register
    localparam logic [SEQ_ML_BITS-1:0] JOB_LEN_SKIP = SEQ_ML_BITS'(JOB_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_SKIP  = 3'd4
    } state_e;

endpackage

// File: rtl/lazy_summary_scheduler.sv
// rtl/lazy_summary_scheduler.sv - job-by-job match request scheduler that turns engine summaries into sequences
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_job_valid/o_job_ready       new-job handshake, i_job_delim marks last job of a block
//   o_match_valid/i_match_ready   one match request at a time, with head pointer and delim
//   i_summary_*                   engine summary strobe and fields (only legal while waiting)
//   o_seq_valid/i_seq_ready       sequence output with ll/ml/offset/eoj/delim
//   o_busy, o_err                 not idle, sticky protocol error
module lazy_summary_scheduler
    import lazy_summary_scheduler_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_job_valid,
    output logic                       o_job_ready,
    input  logic                       i_job_delim,
    output logic                       o_match_valid,
    input  logic                       i_match_ready,
    output logic [JOB_LEN_LOG2-1:0]    o_match_head_ptr,
    output logic                       o_match_delim,
    input  logic                       i_summary_done,
    input  logic [SEQ_LL_BITS-1:0]     i_summary_ll,
    input  logic [SEQ_ML_BITS-1:0]     i_summary_ml,
    input  logic [SEQ_OFFSET_BITS-1:0] i_summary_offset,
    input  logic                       i_summary_eoj,
    input  logic [SEQ_ML_BITS-1:0]     i_summary_overlap_len,
    input  logic                       i_summary_move_to_next_job,
    input  logic [MOVE_BITS-1:0]       i_summary_move_forward,
    output logic                       o_seq_valid,
    input  logic                       i_seq_ready,
    output logic [SEQ_LL_BITS-1:0]     o_seq_ll,
    output logic [SEQ_ML_BITS-1:0]     o_seq_ml,
    output logic [SEQ_OFFSET_BITS-1:0] o_seq_offset,
    output logic                       o_seq_eoj,
    output logic                       o_seq_delim,
    output logic                       o_busy,
    output logic                       o_err
);

    state_e                     state_q, state_d;
    logic [JOB_LEN_LOG2-1:0]    head_q, head_d;
    logic [SEQ_ML_BITS-1:0]     skip_q, skip_d;
    logic                       job_delim_q, job_delim_d;
    logic                       err_q, err_d;

    // captured summary
    logic [SEQ_LL_BITS-1:0]     ll_q, ll_d;
    logic [SEQ_ML_BITS-1:0]     ml_q, ml_d;
    logic [SEQ_OFFSET_BITS-1:0] off_q, off_d;
    logic                       eoj_q, eoj_d;
    logic [SEQ_ML_BITS-1:0]     ovl_q, ovl_d;
    logic                       mtnj_q, mtnj_d;
    // move_forward == JOB_LEN wraps to the same head, so only the low bits matter
    logic [JOB_LEN_LOG2-1:0]    mf_q, mf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            skip_q      <= '0;
            job_delim_q <= 1'b0;
            err_q       <= 1'b0;
            ll_q        <= '0;
            ml_q        <= '0;
            off_q       <= '0;
            eoj_q       <= 1'b0;
            ovl_q       <= '0;
            mtnj_q      <= 1'b0;
            mf_q        <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skip_q      <= skip_d;
            job_delim_q <= job_delim_d;
            err_q       <= err_d;
            ll_q        <= ll_d;
            ml_q        <= ml_d;
            off_q       <= off_d;
            eoj_q       <= eoj_d;
            ovl_q       <= ovl_d;
            mtnj_q      <= mtnj_d;
            mf_q        <= mf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        skip_d      = skip_q;
        job_delim_d = job_delim_q;
        err_d       = err_q;
        ll_d        = ll_q;
        ml_d        = ml_q;
        off_d       = off_q;
        eoj_d       = eoj_q;
        ovl_d       = ovl_q;
        mtnj_d      = mtnj_q;
        mf_d        = mf_q;

        o_job_ready      = 1'b0;
        o_match_valid    = 1'b0;
        o_match_head_ptr = head_q;
        o_match_delim    = 1'b0;
        o_seq_valid      = 1'b0;
        o_seq_ll         = '0;
        o_seq_ml         = '0;
        o_seq_offset     = '0;
        o_seq_eoj        = 1'b0;
        o_seq_delim      = 1'b0;

        // a strobe while no request is outstanding is dropped and flagged
        if (i_summary_done && (state_q != ST_WAIT)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                o_job_ready = 1'b1;
                if (i_job_valid) begin
                    job_delim_d = i_job_delim;
                    if (skip_q < JOB_LEN_SKIP) begin
                        head_d  = skip_q[JOB_LEN_LOG2-1:0];
                        skip_d  = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end

            ST_ISSUE: begin
                o_match_valid = 1'b1;
                o_match_delim = job_delim_q;
                if (i_match_ready) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (i_summary_done) begin
                    ll_d   = i_summary_ll;
                    ml_d   = i_summary_ml;
                    off_d  = i_summary_offset;
                    eoj_d  = i_summary_eoj;
                    ovl_d  = i_summary_overlap_len;
                    mtnj_d = i_summary_move_to_next_job;
                    mf_d   = i_summary_move_forward[JOB_LEN_LOG2-1:0];
                    // zero progress within a job would livelock: end the job instead
                    if ((i_summary_move_forward == '0) && !i_summary_move_to_next_job) begin
                        err_d  = 1'b1;
                        eoj_d  = 1'b1;
                        mtnj_d = 1'b1;
                    end
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                o_seq_valid  = 1'b1;
                o_seq_ll     = ll_q;
                o_seq_ml     = ml_q;
                o_seq_offset = off_q;
                o_seq_eoj    = eoj_q;
                o_seq_delim  = job_delim_q && eoj_q;
                if (i_seq_ready) begin
                    if (!mtnj_q) begin
                        head_d  = head_q + mf_q;
                        state_d = ST_ISSUE;
                    end else begin
                        skip_d  = job_delim_q ? '0 : ovl_q;
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_SKIP: begin
                o_seq_valid = 1'b1;
                o_seq_eoj   = 1'b1;
                o_seq_delim = job_delim_q;
                if (i_seq_ready) begin
                    skip_d  = job_delim_q ? '0 : (skip_q - JOB_LEN_SKIP);
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_err  = err_q;

endmodule

// File: tb/tb_lazy_summary_scheduler.sv
// tb/tb_lazy_summary_scheduler.sv - self-checking bench for lazy_summary_scheduler
module tb_lazy_summary_scheduler;
    import lazy_summary_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_job_valid, o_job_ready, i_job_delim;
    logic        o_match_valid, i_match_ready, o_match_delim;
    logic [5:0]  o_match_head_ptr;
    logic        i_summary_done, i_summary_eoj, i_summary_move_to_next_job;
    logic [7:0]  i_summary_ll, i_summary_ml, i_summary_overlap_len;
    logic [15:0] i_summary_offset;
    logic [6:0]  i_summary_move_forward;
    logic        o_seq_valid, i_seq_ready, o_seq_eoj, o_seq_delim;
    logic [7:0]  o_seq_ll, o_seq_ml;
    logic [15:0] o_seq_offset;
    logic        o_busy, o_err;

    lazy_summary_scheduler dut (
        .clk(clk), .rst(rst),
        .i_job_valid(i_job_valid), .o_job_ready(o_job_ready), .i_job_delim(i_job_delim),
        .o_match_valid(o_match_valid), .i_match_ready(i_match_ready),
        .o_match_head_ptr(o_match_head_ptr), .o_match_delim(o_match_delim),
        .i_summary_done(i_summary_done), .i_summary_ll(i_summary_ll), .i_summary_ml(i_summary_ml),
        .i_summary_offset(i_summary_offset), .i_summary_eoj(i_summary_eoj),
        .i_summary_overlap_len(i_summary_overlap_len),
        .i_summary_move_to_next_job(i_summary_move_to_next_job),
        .i_summary_move_forward(i_summary_move_forward),
        .o_seq_valid(o_seq_valid), .i_seq_ready(i_seq_ready),
        .o_seq_ll(o_seq_ll), .o_seq_ml(o_seq_ml), .o_seq_offset(o_seq_offset),
        .o_seq_eoj(o_seq_eoj), .o_seq_delim(o_seq_delim),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_job(input bit delim);
        int n = 0;
        while (!o_job_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("job_ready_wait", o_job_ready, 1);
        i_job_valid = 1'b1;
        i_job_delim = delim;
        @(negedge clk);
        i_job_valid = 1'b0;
        i_job_delim = 1'b0;
    endtask

    task automatic expect_issue(input logic [5:0] head, input bit delim, input int delay);
        int n = 0;
        while (!o_match_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("match_valid_wait", o_match_valid, 1);
        repeat (delay) @(negedge clk);
        check("match_head", o_match_head_ptr, head);
        check("match_delim", o_match_delim, delim);
        i_match_ready = 1'b1;
        @(negedge clk);
        i_match_ready = 1'b0;
    endtask

    task automatic send_summary(input logic [7:0] ll, input logic [7:0] ml, input logic [15:0] off,
                                input bit eoj, input bit mtnj, input logic [6:0] mf, input logic [7:0] ovl);
        i_summary_done             = 1'b1;
        i_summary_ll               = ll;
        i_summary_ml               = ml;
        i_summary_offset           = off;
        i_summary_eoj              = eoj;
        i_summary_move_to_next_job = mtnj;
        i_summary_move_forward     = mf;
        i_summary_overlap_len      = ovl;
        @(negedge clk);
        i_summary_done = 1'b0;
    endtask

    task automatic expect_seq(input logic [7:0] ll, input logic [7:0] ml, input logic [15:0] off,
                              input bit eoj, input bit delim, input int delay);
        int n = 0;
        while (!o_seq_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("seq_valid_wait", o_seq_valid, 1);
        repeat (delay) @(negedge clk);
        check("seq_ll", o_seq_ll, ll);
        check("seq_ml", o_seq_ml, ml);
        check("seq_offset", o_seq_offset, off);
        check("seq_eoj", o_seq_eoj, eoj);
        check("seq_delim", o_seq_delim, delim);
        i_seq_ready = 1'b1;
        @(negedge clk);
        i_seq_ready = 1'b0;
    endtask

    typedef struct {
        bit         new_job;
        bit         delim;
        bit         skip;
        logic [5:0] head;
        logic [7:0] ll, ml;
        logic [15:0] off;
        bit         eoj, mtnj;
        logic [6:0] mf;
        logic [7:0] ovl;
        bit         sdelim;
    } vec_t;

    function automatic vec_t mk(bit nj, bit d, bit s, logic [5:0] h, logic [7:0] ll, logic [7:0] ml,
                                logic [15:0] off, bit eoj, bit mtnj, logic [6:0] mf, logic [7:0] ovl, bit sd);
        vec_t v;
        v.new_job = nj; v.delim = d; v.skip = s; v.head = h; v.ll = ll; v.ml = ml; v.off = off;
        v.eoj = eoj; v.mtnj = mtnj; v.mf = mf; v.ovl = ovl; v.sdelim = sd;
        return v;
    endfunction

    vec_t vecs[$];
    bit   cur_delim;
    int   m_skip;
    int   m_head;
    logic [7:0]  r_ll, r_ml, r_ovl;
    logic [15:0] r_off;
    bit          r_eoj, r_mtnj, r_d;
    logic [6:0]  r_mf;
    logic [7:0]  h_ll, h_ml;
    logic [15:0] h_off;
    bit          stable;

    initial begin
        rst = 1'b1;
        i_job_valid = 0; i_job_delim = 0; i_match_ready = 0; i_seq_ready = 0;
        i_summary_done = 0; i_summary_ll = 0; i_summary_ml = 0; i_summary_offset = 0;
        i_summary_eoj = 0; i_summary_move_to_next_job = 0; i_summary_move_forward = 0;
        i_summary_overlap_len = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_job_ready", o_job_ready, 1);
        check("rst_match_valid", o_match_valid, 0);
        check("rst_seq_valid", o_seq_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_err", o_err, 0);
        check("rst_head", o_match_head_ptr, 0);
        check("rst_seq_fields", {o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim}, 0);

        //          nj d  s  head ll ml off  eoj mtnj mf  ovl  sdelim
        vecs.push_back(mk(1, 0, 0, 0,  3, 4, 100, 0, 0, 10, 0,   0));
        vecs.push_back(mk(0, 0, 0, 10, 5, 6, 200, 1, 1, 1,  5,   0));
        vecs.push_back(mk(1, 0, 0, 5,  1, 1, 1,   1, 1, 1,  70,  0));
        vecs.push_back(mk(1, 0, 1, 0,  0, 0, 0,   1, 0, 0,  0,   0));
        vecs.push_back(mk(1, 0, 0, 6,  2, 3, 50,  0, 0, 60, 0,   0));
        vecs.push_back(mk(0, 0, 0, 2,  8, 9, 10,  1, 1, 5,  0,   0));
        vecs.push_back(mk(1, 1, 0, 0,  4, 4, 4,   0, 0, 3,  0,   0));
        vecs.push_back(mk(0, 1, 0, 3,  4, 4, 4,   1, 1, 1,  9,   1));
        vecs.push_back(mk(1, 0, 0, 0,  6, 7, 8,   1, 1, 1,  130, 0));
        vecs.push_back(mk(1, 0, 1, 0,  0, 0, 0,   1, 0, 0,  0,   0));
        vecs.push_back(mk(1, 1, 1, 0,  0, 0, 0,   1, 0, 0,  0,   1));
        vecs.push_back(mk(1, 0, 0, 0,  9, 9, 9,   0, 0, 64, 0,   0));
        vecs.push_back(mk(0, 0, 0, 0,  1, 1, 1,   1, 1, 1,  0,   0));

        foreach (vecs[i]) begin
            if (vecs[i].new_job) begin
                cur_delim = vecs[i].delim;
                do_job(cur_delim);
            end
            if (vecs[i].skip) begin
                check("skip_latency", o_seq_valid, 1);
                expect_seq(0, 0, 0, 1, vecs[i].sdelim, 0);
            end else begin
                check("issue_latency", o_match_valid, 1);
                expect_issue(vecs[i].head, cur_delim, 0);
                send_summary(vecs[i].ll, vecs[i].ml, vecs[i].off, vecs[i].eoj, vecs[i].mtnj,
                             vecs[i].mf, vecs[i].ovl);
                check("emit_latency", o_seq_valid, 1);
                expect_seq(vecs[i].ll, vecs[i].ml, vecs[i].off, vecs[i].eoj, vecs[i].sdelim, 0);
                if (!vecs[i].mtnj) check("reissue_latency", o_match_valid, 1);
            end
        end

        // randomized traffic against a job-level reference model
        m_skip = 0;
        for (int j = 0; j < 40; j++) begin
            r_d = ($urandom_range(0, 3) == 0);
            do_job(r_d);
            if (m_skip >= JOB_LEN) begin
                expect_seq(0, 0, 0, 1, r_d, $urandom_range(0, 3));
                m_skip = r_d ? 0 : m_skip - JOB_LEN;
                continue;
            end
            m_head = m_skip;
            m_skip = 0;
            for (int k = 0; k < 6; k++) begin
                expect_issue(6'(m_head), r_d, $urandom_range(0, 3));
                r_ll   = 8'($urandom);
                r_ml   = 8'($urandom);
                r_off  = 16'($urandom);
                r_eoj  = $urandom_range(0, 1);
                r_ovl  = 8'($urandom_range(0, 200));
                r_mtnj = (k == 5) || ($urandom_range(0, 3) == 0);
                r_mf   = 7'($urandom_range(1, JOB_LEN));
                send_summary(r_ll, r_ml, r_off, r_eoj, r_mtnj, r_mf, r_ovl);
                expect_seq(r_ll, r_ml, r_off, r_eoj, r_d && r_eoj, $urandom_range(0, 3));
                if (r_mtnj) begin
                    m_skip = r_d ? 0 : int'(r_ovl);
                    break;
                end
                m_head = (m_head + int'(r_mf)) % JOB_LEN;
            end
        end
        check("rand_no_err", o_err, 0);

        // backpressure in EMIT, then a stray summary in IDLE
        do_reset();
        do_job(0);
        expect_issue(0, 0, 0);
        send_summary(7, 9, 300, 0, 1, 1, 0);
        h_ll = o_seq_ll; h_ml = o_seq_ml; h_off = o_seq_offset;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!o_seq_valid || o_match_valid || o_seq_ll !== h_ll || o_seq_ml !== h_ml ||
                o_seq_offset !== h_off)
                stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        expect_seq(7, 9, 300, 0, 0, 0);
        check("bp_err_clear", o_err, 0);
        send_summary(1, 1, 1, 1, 1, 1, 0);
        check("idle_strobe_err", o_err, 1);
        check("idle_strobe_busy", o_busy, 0);
        check("idle_strobe_job_ready", o_job_ready, 1);

        // reset while waiting for a summary, then the late summary
        do_reset();
        check("rst2_err", o_err, 0);
        do_job(0);
        expect_issue(0, 0, 0);
        check("wait_busy", o_busy, 1);
        do_reset();
        check("midrst_busy", o_busy, 0);
        check("midrst_job_ready", o_job_ready, 1);
        check("midrst_match_valid", o_match_valid, 0);
        check("midrst_seq_valid", o_seq_valid, 0);
        check("midrst_err", o_err, 0);
        check("midrst_head", o_match_head_ptr, 0);
        send_summary(2, 2, 2, 1, 1, 1, 4);
        check("late_sum_err", o_err, 1);
        check("late_sum_seq_valid", o_seq_valid, 0);
        check("late_sum_busy", o_busy, 0);

        // zero move_forward without move_to_next_job ends the job with an error
        do_reset();
        do_job(0);
        expect_issue(0, 0, 0);
        send_summary(1, 2, 3, 0, 0, 0, 3);
        check("mf0_err", o_err, 1);
        check("mf0_seq_valid", o_seq_valid, 1);
        i_seq_ready = 1'b1;
        @(negedge clk);
        i_seq_ready = 1'b0;
        check("mf0_to_idle", o_busy, 0);
        do_job(0);
        expect_issue(3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
